// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN feature-map pipeline (conv2d -> relu_maxpool2d).
//   CNN_DATA_WIDTH : default signed element width shared by all stages
//   CNN_FRAC_BITS  : default fixed-point fraction bits shared with conv2d
//   pool_state_t   : state encoding of the pooling sequencer
//   max2()         : signed 2-input max, evaluated on sign-extended operands so
//                    one function serves any element width up to MAX2_W bits
// ---------------------------------------------------------------------------
package cnn_pkg;

  localparam int CNN_DATA_WIDTH = 16;
  localparam int CNN_FRAC_BITS  = 8;

  // Operand width of max2; callers sign-extend into it and truncate the result.
  localparam int MAX2_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POOL   = 2'd1,
    FINISH = 2'd2
  } pool_state_t;

  function automatic logic signed [MAX2_W-1:0] max2(
    input logic signed [MAX2_W-1:0] a,
    input logic signed [MAX2_W-1:0] b
  );
    logic signed [MAX2_W-1:0] m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/max4_signed.sv
// ---------------------------------------------------------------------------
// max4_signed
// Combinational signed maximum of four elements of one 2x2 pooling window.
// Optional macro RELU_FUSE_EN: when defined the result is clamped at zero
// (fused ReLU); when undefined the raw maximum is passed through.
// Ports:
//   a, b, c, d : input  signed [DATA_WIDTH-1:0]  window elements
//   y          : output signed [DATA_WIDTH-1:0]  max of the four (ReLU'd if enabled)
// The result is always one of the inputs or zero; no widening or saturation.
// ---------------------------------------------------------------------------
module max4_signed
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] c,
  input  logic signed [DATA_WIDTH-1:0] d,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [MAX2_W-1:0]     a_x_s;
  logic signed [MAX2_W-1:0]     b_x_s;
  logic signed [MAX2_W-1:0]     c_x_s;
  logic signed [MAX2_W-1:0]     d_x_s;
  logic signed [DATA_WIDTH-1:0] max_s;

  // Sign-extend the window into the shared max2 operand width.
  assign a_x_s = MAX2_W'(a);
  assign b_x_s = MAX2_W'(b);
  assign c_x_s = MAX2_W'(c);
  assign d_x_s = MAX2_W'(d);

  // Balanced two-level max tree, then the optional zero clamp.
  always_comb begin
    max_s = DATA_WIDTH'(max2(max2(a_x_s, b_x_s), max2(c_x_s, d_x_s)));
`ifdef RELU_FUSE_EN
    if (max_s[DATA_WIDTH-1]) begin
      y = {DATA_WIDTH{1'b0}};
    end else begin
      y = max_s;
    end
`else
    y = max_s;
`endif
  end

endmodule

// File: rtl/relu_maxpool2d.sv
// ---------------------------------------------------------------------------
// relu_maxpool2d
// Fused ReLU + 2x2/stride-2 max-pool over a full CHANNELS x IMG_SIZE x IMG_SIZE
// signed feature map. One pooled element is written per clock, scanning
// column fastest, then row, then channel. Odd IMG_SIZE drops the last row and
// column (floor pooling).
// Optional macro RELU_FUSE_EN (inside max4_signed): clamp negatives to zero.
// Ports:
//   clk         : input  rising-edge clock
//   reset_n     : input  asynchronous active-low reset (clears all outputs)
//   start       : input  begin a run; only looked at in IDLE
//   in_feature  : input  signed [DATA_WIDTH-1:0] [CHANNELS][IMG_SIZE][IMG_SIZE],
//                 held stable by upstream while busy
//   out_feature : output signed [DATA_WIDTH-1:0] [CHANNELS][OUT_SIZE][OUT_SIZE],
//                 registered, held until overwritten by a later run
//   busy        : output high from the cycle after start is taken through FINISH
//   done        : output one-cycle pulse once the whole pooled map is valid
// ---------------------------------------------------------------------------
module relu_maxpool2d
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_feature  [0:CHANNELS-1][0:IMG_SIZE-1][0:IMG_SIZE-1],
  output logic signed [DATA_WIDTH-1:0] out_feature [0:CHANNELS-1][0:IMG_SIZE/2-1][0:IMG_SIZE/2-1],
  output logic                         busy,
  output logic                         done
);

  localparam int OUT_SIZE = IMG_SIZE / 2;

  // Counter / index widths, kept at least one bit for degenerate sizes.
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int IW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [OW-1:0] RC_LAST = OW'(OUT_SIZE - 1);
  localparam logic [CW-1:0] CH_ONE  = CW'(1);
  localparam logic [OW-1:0] RC_ONE  = OW'(1);

  pool_state_t                 state_r;
  logic [CW-1:0]               ch_r;
  logic [OW-1:0]               r_r;
  logic [OW-1:0]               c_r;
  logic [IW-1:0]               row0_s;
  logic [IW-1:0]               row1_s;
  logic [IW-1:0]               col0_s;
  logic [IW-1:0]               col1_s;
  logic signed [DATA_WIDTH-1:0] pooled_s;

  // Input window origin is (2r, 2c); appending a 0/1 LSB forms 2r and 2r+1.
  assign row0_s = IW'({r_r, 1'b0});
  assign row1_s = IW'({r_r, 1'b1});
  assign col0_s = IW'({c_r, 1'b0});
  assign col1_s = IW'({c_r, 1'b1});

  max4_signed #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_max4 (
    .a (in_feature[ch_r][row0_s][col0_s]),
    .b (in_feature[ch_r][row0_s][col1_s]),
    .c (in_feature[ch_r][row1_s][col0_s]),
    .d (in_feature[ch_r][row1_s][col1_s]),
    .y (pooled_s)
  );

  // Sequencer: IDLE -> POOL (one output per edge) -> FINISH (done pulse) -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      ch_r    <= {CW{1'b0}};
      r_r     <= {OW{1'b0}};
      c_r     <= {OW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        for (int j = 0; j < OUT_SIZE; j++) begin
          for (int k = 0; k < OUT_SIZE; k++) begin
            out_feature[i][j][k] <= {DATA_WIDTH{1'b0}};
          end
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ch_r    <= {CW{1'b0}};
            r_r     <= {OW{1'b0}};
            c_r     <= {OW{1'b0}};
            busy    <= 1'b1;
            state_r <= POOL;
          end
        end
        POOL: begin
          out_feature[ch_r][r_r][c_r] <= pooled_s;
          if (c_r == RC_LAST) begin
            c_r <= {OW{1'b0}};
            if (r_r == RC_LAST) begin
              r_r <= {OW{1'b0}};
              if (ch_r == CH_LAST) begin
                ch_r    <= {CW{1'b0}};
                state_r <= FINISH;
              end else begin
                ch_r <= ch_r + CH_ONE;
              end
            end else begin
              r_r <= r_r + RC_ONE;
            end
          end else begin
            c_r <= c_r + RC_ONE;
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool2d.sv
// ---------------------------------------------------------------------------
// tb_relu_maxpool2d
// Bench for relu_maxpool2d: a default-size instance checked every cycle
// against a timeline/array model, plus a 5x5, 2-channel instance checked with
// hand-computed values. Works with or without RELU_FUSE_EN defined.
// ---------------------------------------------------------------------------
module tb_relu_maxpool2d;

  localparam int DW  = 16;
  localparam int CH  = 8;
  localparam int IS  = 28;
  localparam int OS  = 14;
  localparam int N   = CH * OS * OS;   // 1568
  localparam int SCH = 2;
  localparam int SIS = 5;
  localparam int SOS = 2;

`ifdef RELU_FUSE_EN
  localparam int NEG_WIN_EXP = 0;
`else
  localparam int NEG_WIN_EXP = -1;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic start_s;
  logic busy, done, busy_s, done_s;

  logic signed [DW-1:0] in_feat  [0:CH-1][0:IS-1][0:IS-1];
  logic signed [DW-1:0] out_feat [0:CH-1][0:OS-1][0:OS-1];
  logic signed [DW-1:0] in_sm    [0:SCH-1][0:SIS-1][0:SIS-1];
  logic signed [DW-1:0] out_sm   [0:SCH-1][0:SOS-1][0:SOS-1];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;   // posedges seen so far
  int e0     = 0;   // edge number at which the current run was accepted
  int e0s    = 0;

  // Behavioural model state.
  logic signed [DW-1:0] exp_out [0:CH-1][0:OS-1][0:OS-1];
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_k      = 0;

  always #5 clk = ~clk;

  relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IS)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_feature(in_feat),
    .out_feature(out_feat), .busy(busy), .done(done)
  );

  relu_maxpool2d #(.DATA_WIDTH(DW), .CHANNELS(SCH), .IMG_SIZE(SIS)) dut_sm (
    .clk(clk), .reset_n(reset_n), .start(start_s), .in_feature(in_sm),
    .out_feature(out_sm), .busy(busy_s), .done(done_s)
  );

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, got, expv);
    end
  endtask

  // Reference pooled value straight from the definition: max of the 2x2 window.
  function automatic int pool_ref(int ch, int r, int c);
    int best = -(1 << 20);
    for (int di = 0; di < 2; di++) begin
      for (int dj = 0; dj < 2; dj++) begin
        if (int'(in_feat[ch][2*r+di][2*c+dj]) > best) best = int'(in_feat[ch][2*r+di][2*c+dj]);
      end
    end
`ifdef RELU_FUSE_EN
    if (best < 0) best = 0;
`endif
    return best;
  endfunction

  // Model timeline: run accepted at E0, element k (scan order) lands at E(k),
  // done is high for the cycle after E(N+1); start is only taken when idle.
  always @(posedge clk) begin : model
    int idx;
    cyc++;
    if (!reset_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      for (int i = 0; i < CH; i++)
        for (int j = 0; j < OS; j++)
          for (int k = 0; k < OS; k++) exp_out[i][j][k] = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k <= N) begin
          idx = m_k - 1;
          exp_out[idx/(OS*OS)][(idx/OS)%OS][idx%OS] = DW'(pool_ref(idx/(OS*OS), (idx/OS)%OS, idx%OS));
        end else begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_k      = 0;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : compare
    int bad, fi, fj, fk, fa, fe, want;
    check("busy", busy, reset_n ? m_active : 1'b0);
    check("done", done, reset_n ? m_done : 1'b0);
    bad = 0; fi = 0; fj = 0; fk = 0; fa = 0; fe = 0;
    for (int i = 0; i < CH; i++) begin
      for (int j = 0; j < OS; j++) begin
        for (int k = 0; k < OS; k++) begin
          want = reset_n ? int'(exp_out[i][j][k]) : 0;
          if (out_feat[i][j][k] !== DW'(want)) begin
            if (bad == 0) begin
              fi = i; fj = j; fk = k; fa = int'(out_feat[i][j][k]); fe = want;
            end
            bad++;
          end
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL out_feature map at cycle %0d: %0d elements differ, first [%0d][%0d][%0d] actual %0d required %0d",
               cyc, bad, fi, fj, fk, fa, fe);
    end
  end

  task automatic fill_random();
    for (int i = 0; i < CH; i++)
      for (int j = 0; j < IS; j++)
        for (int k = 0; k < IS; k++) in_feat[i][j][k] = DW'($urandom);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_at(input int e);
    wait_edge(e - 1); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int off);
    off = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        off = cyc - e0;
        break;
      end
    end
  endtask

  task automatic run_small(input string tag);
    int off;
    @(negedge clk); #1;
    start_s = 1'b1;
    e0s = cyc + 1;
    @(negedge clk); #1;
    start_s = 1'b0;
    off = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_s === 1'b1) begin
        off = cyc - e0s;
        break;
      end
    end
    check({tag, " done edge"}, off, 9);
    check({tag, " out[0][0][0]"}, out_sm[0][0][0], 6);
    check({tag, " out[0][1][1]"}, out_sm[0][1][1], 18);
    check({tag, " out[1][0][1]"}, out_sm[1][0][1], 108);
    check({tag, " out[1][1][0]"}, out_sm[1][1][0], 116);
    check({tag, " busy after"}, busy_s, 1'b0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int off;
    int nz;
    reset_n = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    for (int i = 0; i < CH; i++)
      for (int j = 0; j < IS; j++)
        for (int k = 0; k < IS; k++) in_feat[i][j][k] = '0;
    for (int i = 0; i < SCH; i++)
      for (int j = 0; j < SIS; j++)
        for (int k = 0; k < SIS; k++) in_sm[i][j][k] = DW'(i*100 + j*5 + k);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk); #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset out[0][0][0]", out_feat[0][0][0], 0);
    check("reset out[7][13][13]", out_feat[7][13][13], 0);

    // Run A: random map with directed windows; starts during busy are ignored.
    fill_random();
    in_feat[0][0][0] = 5;           in_feat[0][0][1] = -3;
    in_feat[0][1][0] = 12;          in_feat[0][1][1] = 7;
    in_feat[1][0][0] = -1;          in_feat[1][0][1] = -8;
    in_feat[1][1][0] = -128;        in_feat[1][1][1] = -2;
    in_feat[2][0][0] = 16'sh8000;   in_feat[2][0][1] = 16'sh7FFF;
    in_feat[2][1][0] = 16'sh8000;   in_feat[2][1][1] = 16'sh8000;
    pulse_start();
    wait_edge(e0 + 1); #1;
    check("A out[0][0][0] at E1", out_feat[0][0][0], 12);
    check("A model out[0][0][0]", exp_out[0][0][0], 12);
    pulse_at(e0 + 10);
    pulse_at(e0 + 500);
    wait_done(4000, off);
    check("A done edge", off, N + 1);
    check("A out[1][0][0] negative window", out_feat[1][0][0], NEG_WIN_EXP);
    check("A model out[1][0][0]", exp_out[1][0][0], NEG_WIN_EXP);
    check("A out[2][0][0] extremes", out_feat[2][0][0], 32767);
    repeat (5) @(negedge clk);

    // Runs B/C: ramp map with start held high, back-to-back runs.
    for (int i = 0; i < CH; i++)
      for (int j = 0; j < IS; j++)
        for (int k = 0; k < IS; k++) in_feat[i][j][k] = DW'(i*1000 + j*28 + k);
    #1;
    start = 1'b1;
    e0 = cyc + 1;
    wait_done(4000, off);
    check("B first done edge", off, N + 1);
    wait_done(4000, off);
    #1 start = 1'b0;
    check("B second done edge", off, 2*N + 3);
    check("B out[3][13][13]", out_feat[3][13][13], 3783);
    check("B out[1][2][5]", out_feat[1][2][5], 1151);
    check("B out[7][0][0]", out_feat[7][0][0], 7029);
    check("B model out[3][13][13]", exp_out[3][13][13], 3783);
    repeat (5) @(negedge clk);

    // Run D: asynchronous reset in the middle of a run.
    fill_random();
    pulse_start();
    wait_edge(e0 + 700); #1;
    check("D busy before reset", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("D busy in reset", busy, 1'b0);
    check("D done in reset", done, 1'b0);
    nz = 0;
    for (int i = 0; i < CH; i++)
      for (int j = 0; j < OS; j++)
        for (int k = 0; k < OS; k++) if (out_feat[i][j][k] !== '0) nz++;
    check("D nonzero outputs in reset", nz, 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Run E: fresh run after reset.
    fill_random();
    pulse_start();
    wait_done(4000, off);
    check("E done edge", off, N + 1);
    repeat (3) @(negedge clk);

    // Small instance: 5x5, 2 channels; row 4 / column 4 must never matter.
    run_small("S1");
    for (int i = 0; i < SCH; i++) begin
      for (int j = 0; j < SIS; j++) begin
        in_sm[i][4][j] = 16'sh7FFF;
        in_sm[i][j][4] = 16'sh7FFF;
      end
    end
    run_small("S2");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
